// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit:
// FSM states, opcodes and ALU operation codes.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM    = 4'd4,
    S_WB     = 4'd5,
    S_HALT   = 4'd6
  } state_e;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h6;
  localparam logic [3:0] OP_BEQ = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_NOT = 3'd4
  } alu_op_e;

  function automatic logic op_legal(
    input logic [3:0] op
  );
    return (op <= OP_JMP) || (op == OP_HLT);
  endfunction

  function automatic logic op_is_alu(
    input logic [3:0] op
  );
    return op <= OP_NOT;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Memory-wait up-counter with clear, increment and
// terminal-count compare, clocked on the falling edge.
module wait_timer #(
  parameter int unsigned W  = 8,
  parameter int unsigned TC = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [W-1:0] TCV = W'(TC);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TCV);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FSM sequencing fetch/decode/execute/memory/
// writeback load enables, with memory-ready timeout.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNTW    = 8
) (
  input  logic            CLK,
  input  logic            R,
  input  logic            START,
  input  logic [3:0]      OPCODE,
  input  logic            ZERO,
  input  logic            MEM_RDY,
  output logic            MEM_RD,
  output logic            MEM_WR,
  output logic            PC_LD,
  output logic            PC_SEL,
  output logic            IR_LD,
  output logic            AB_LD,
  output logic            MDR_LD,
  output logic            RF_WE,
  output logic            RF_SRC,
  output logic [2:0]      ALU_OP,
  output logic            ILLEGAL,
  output logic            ERR,
  output logic            HALTED,
  output logic [CNTW-1:0] ICNT
);

  state_e            state_q;
  state_e            state_d;
  logic              err_q;
  logic              err_d;
  logic [CNTW-1:0]   icnt_q;
  logic [CNTW-1:0]   icnt_d;
  logic              waiting;
  logic              icnt_inc;
  logic              err_set;
  logic              tmr_clr;
  logic              tmr_inc;
  logic              tmr_tc;

  // A count at TIMEOUT only faults if ready is still low.
  assign tmr_clr = !waiting || (state_d != state_q);
  assign tmr_inc = waiting && !MEM_RDY;

  wait_timer #(
    .W  (8),
    .TC (TIMEOUT)
  ) u_wait_timer (
    .clk_i  (CLK),
    .rst_ni (R),
    .clr_i  (tmr_clr),
    .inc_i  (tmr_inc),
    .tc_o   (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    waiting  = 1'b0;
    icnt_inc = 1'b0;
    err_set  = 1'b0;
    MEM_RD   = 1'b0;
    MEM_WR   = 1'b0;
    PC_LD    = 1'b0;
    PC_SEL   = 1'b0;
    IR_LD    = 1'b0;
    AB_LD    = 1'b0;
    MDR_LD   = 1'b0;
    RF_WE    = 1'b0;
    RF_SRC   = 1'b0;
    ALU_OP   = ALU_ADD;
    ILLEGAL  = 1'b0;
    HALTED   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        waiting = 1'b1;
        MEM_RD  = 1'b1;
        if (MEM_RDY) begin
          IR_LD   = 1'b1;
          PC_LD   = 1'b1;
          state_d = S_DECODE;
        end else if (tmr_tc) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        AB_LD    = 1'b1;
        icnt_inc = 1'b1;
        unique case (1'b1)
          OPCODE == OP_HLT: state_d = S_HALT;
          !op_legal(OPCODE): begin
            ILLEGAL = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        unique case (1'b1)
          op_is_alu(OPCODE): begin
            ALU_OP  = OPCODE[2:0];
            state_d = S_WB;
          end
          OPCODE == OP_LD,
          OPCODE == OP_ST: begin
            ALU_OP  = ALU_ADD;
            state_d = S_MEM;
          end
          OPCODE == OP_BEQ: begin
            ALU_OP  = ALU_SUB;
            PC_LD   = ZERO;
            PC_SEL  = ZERO;
            state_d = S_FETCH;
          end
          OPCODE == OP_JMP: begin
            PC_LD   = 1'b1;
            PC_SEL  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        waiting = 1'b1;
        MEM_WR  = (OPCODE == OP_ST);
        MEM_RD  = (OPCODE != OP_ST);
        if (MEM_RDY) begin
          MDR_LD  = (OPCODE != OP_ST);
          state_d = (OPCODE == OP_ST) ? S_FETCH : S_WB;
        end else if (tmr_tc) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end
      end
      S_WB: begin
        RF_WE   = 1'b1;
        RF_SRC  = (OPCODE == OP_LD);
        state_d = S_FETCH;
      end
      S_HALT: begin
        HALTED = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err_d  = err_q | err_set;
  assign icnt_d = icnt_inc ? icnt_q + CNTW'(1) : icnt_q;

  always_ff @(negedge CLK or negedge R) begin
    if (!R) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      icnt_q  <= icnt_d;
    end
  end

  assign ERR  = err_q;
  assign ICNT = icnt_q;

endmodule
